// File: rtl/disp_split_ctrl_pkg.sv
// disp_split_ctrl_pkg: shared FSM encoding, segment codes and scan default for disp_split_ctrl
package disp_split_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, DIV1, DIV2, DIV3, DONE} state_t;
  localparam int SCAN_DIV_DEF = 50000;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 8'hC0;
      4'd1: seg_of = 8'hF9;
      4'd2: seg_of = 8'hA4;
      4'd3: seg_of = 8'hB0;
      4'd4: seg_of = 8'h99;
      4'd5: seg_of = 8'h92;
      4'd6: seg_of = 8'h82;
      4'd7: seg_of = 8'hF8;
      4'd8: seg_of = 8'h80;
      4'd9: seg_of = 8'h90;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/calc_div.sv
// calc_div: combinational unsigned divider
//   a   : dividend (W bits)      b : divisor (16 bits)
//   q   : quotient (W bits)      r : remainder (16 bits)
//   neg : sign of the quotient if a and b were read as signed
module calc_div #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [15:0]  b,
  output logic [W-1:0] q,
  output logic [15:0]  r,
  output logic         neg
);
  assign q   = a / W'(b);
  assign r   = 16'(a % W'(b));
  assign neg = a[W-1] ^ b[15];
endmodule

// File: rtl/disp_split_ctrl.sv
// disp_split_ctrl: signed 16-bit value to 4-digit BCD split plus multiplexed 7-segment scan
//   sys_clk, sys_rst_n : clock, async active-low reset
//   in_valid/in_v/in_ready : value handshake (in_ready high only when idle)
//   done : one-cycle pulse as new bcd/neg/ovf appear
//   neg, ovf, bcd : latched sign, overflow flag, digits {thd,hud,ten,one}
//   seg, sel : active-low segments {dp,g..a} and active-low digit enables
module disp_split_ctrl
  import disp_split_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_v,
  output logic        in_ready,
  output logic        done,
  output logic        neg,
  output logic        ovf,
  output logic [15:0] bcd,
  output logic [7:0]  seg,
  output logic [3:0]  sel
);
  state_t      state_q;
  logic [15:0] in_q, bcd_q, cnt_q;
  logic [16:0] work_q, div_q, mag;
  logic [15:0] div_r;
  logic [11:0] unused_div_r;
  logic        unused_div_neg;
  logic [3:0]  one_q, ten_q, hud_q, sel_q;
  logic        sign_q, ovf_w_q, rdy_q, done_q, neg_q, ovf_q;
  logic [1:0]  idx_q, top_d;
  logic [7:0]  seg_q, seg_d;
  logic        wrap;

  calc_div #(.W(17)) u_div (
    .a  (work_q),
    .b  (16'd10),
    .q  (div_q),
    .r  (div_r),
    .neg(unused_div_neg)
  );

  assign unused_div_r = div_r[15:4];
  // sign-extend before negating so -32768 becomes +32768
  assign mag   = in_q[15] ? -{in_q[15], in_q} : {1'b0, in_q};
  assign wrap  = cnt_q == 16'(SCAN_DIV - 1);
  // highest digit position that is shown; ones is always shown
  assign top_d = bcd_q[15:12] != 4'd0 ? 2'd3 : bcd_q[11:8] != 4'd0 ? 2'd2 : bcd_q[7:4] != 4'd0 ? 2'd1 : 2'd0;
  assign seg_d = ovf_q ? SEG_MINUS :
                 idx_q <= top_d ? seg_of(bcd_q[{idx_q, 2'b00} +: 4]) :
                 (neg_q && idx_q == top_d + 2'd1) ? SEG_MINUS : SEG_BLANK;

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= IDLE;
      in_q    <= '0;
      work_q  <= '0;
      one_q   <= '0;
      ten_q   <= '0;
      hud_q   <= '0;
      sign_q  <= 1'b0;
      ovf_w_q <= 1'b0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          in_q    <= in_v;
          rdy_q   <= 1'b0;
          state_q <= LOAD;
        end
        LOAD: begin
          work_q  <= mag;
          sign_q  <= in_q[15];
          ovf_w_q <= in_q[15] ? mag > 17'd999 : mag > 17'd9999;
          state_q <= DIV1;
        end
        DIV1: begin
          one_q   <= div_r[3:0];
          work_q  <= div_q;
          state_q <= DIV2;
        end
        DIV2: begin
          ten_q   <= div_r[3:0];
          work_q  <= div_q;
          state_q <= DIV3;
        end
        DIV3: begin
          hud_q   <= div_r[3:0];
          work_q  <= div_q;
          state_q <= DONE;
        end
        DONE: begin
          bcd_q   <= ovf_w_q ? 16'h0 : {work_q[3:0], hud_q, ten_q, one_q};
          neg_q   <= sign_q;
          ovf_q   <= ovf_w_q;
          done_q  <= 1'b1;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      sel_q <= 4'b1110;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= wrap ? 16'd0 : cnt_q + 16'd1;
      idx_q <= wrap ? idx_q + 2'd1 : idx_q;
      sel_q <= ~(4'b0001 << idx_q);
      seg_q <= seg_d;
    end

  assign in_ready = rdy_q;
  assign done     = done_q;
  assign neg      = neg_q;
  assign ovf      = ovf_q;
  assign bcd      = bcd_q;
  assign seg      = seg_q;
  assign sel      = sel_q;
endmodule

// File: tb/tb_disp_split_ctrl.sv
// tb_disp_split_ctrl: randomized and directed checks of disp_split_ctrl against a behavioural model
module tb_disp_split_ctrl;
  localparam int D = 4;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [15:0] in_v = '0;
  logic        in_ready, done, neg, ovf;
  logic [15:0] bcd;
  logic [7:0]  seg;
  logic [3:0]  sel;
  int vectors = 0, errors = 0;

  disp_split_ctrl #(.SCAN_DIV(D)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(in_valid), .in_v(in_v),
    .in_ready(in_ready), .done(done), .neg(neg), .ovf(ovf),
    .bcd(bcd), .seg(seg), .sel(sel)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input byte c);
    case (c)
      "0": return 8'hC0;
      "1": return 8'hF9;
      "2": return 8'hA4;
      "3": return 8'hB0;
      "4": return 8'h99;
      "5": return 8'h92;
      "6": return 8'h82;
      "7": return 8'hF8;
      "8": return 8'h80;
      "9": return 8'h90;
      "-": return 8'hBF;
      default: return 8'hFF;
    endcase
  endfunction

  // display is the value printed right-justified in four characters, or "----" if it does not fit
  function automatic void convert(input logic [15:0] raw, output logic [15:0] b,
                                  output logic n, output logic o, output string s);
    int v, m;
    v = $signed(raw);
    n = v < 0;
    m = n ? -v : v;
    o = v > 9999 || v < -999;
    b = o ? 16'h0 : 16'((m / 1000 % 10) * 4096 + (m / 100 % 10) * 256 + (m / 10 % 10) * 16 + m % 10);
    s = o ? "----" : $sformatf("%4d", v);
  endfunction

  logic        m_ready, m_done, m_neg, m_ovf;
  logic [15:0] m_bcd, m_pend;
  logic [7:0]  m_seg;
  logic [3:0]  m_sel;
  int          m_cnt, m_edges;
  string       m_str;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_ready = 1'b1; m_done = 1'b0; m_neg = 1'b0; m_ovf = 1'b0; m_bcd = '0; m_pend = '0;
      m_str = "   0"; m_cnt = 0; m_edges = 0; m_sel = 4'b1110; m_seg = 8'hFF;
    end else begin : mdl
      int p;
      p = (m_edges / D) % 4;
      m_sel = ~(4'b0001 << p);
      m_seg = glyph(m_str[3-p]);
      m_edges++;
      m_done = 1'b0;
      if (m_cnt == 0 && in_valid) begin
        m_cnt = 5; m_pend = in_v; m_ready = 1'b0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          convert(m_pend, m_bcd, m_neg, m_ovf, m_str);
          m_done = 1'b1; m_ready = 1'b1;
        end
      end
    end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      chk("in_ready", 16'(in_ready), 16'(m_ready));
      chk("done", 16'(done), 16'(m_done));
      chk("neg", 16'(neg), 16'(m_neg));
      chk("ovf", 16'(ovf), 16'(m_ovf));
      chk("bcd", bcd, m_bcd);
      chk("seg", 16'(seg), 16'(m_seg));
      chk("sel", 16'(sel), 16'(m_sel));
    end

  task automatic send(input logic [15:0] v, output int lat);
    int guard;
    in_valid = 1'b1; in_v = v; guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
    chk("ready wait", 16'(guard < 20), 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_v = 16'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 12) begin @(posedge clk); #1; lat++; end
  endtask

  // e[p] is the required segment code while sel enables position p (0 = ones)
  task automatic scan_chk(input string nm, input logic [7:0] e3, e2, e1, e0);
    logic [7:0] e [4];
    logic [3:0] want;
    int g;
    e = '{e0, e1, e2, e3};
    repeat (2) @(posedge clk);
    for (int p = 0; p < 4; p++) begin
      want = ~(4'b0001 << p);
      g = 0;
      do begin @(negedge clk); g++; end while (sel !== want && g < 4 * D + 4);
      chk({nm, " sel"}, 16'(sel), 16'(want));
      chk({nm, " seg"}, 16'(seg), 16'(e[p]));
    end
  endtask

  task automatic conv(input logic [15:0] v, input logic [15:0] eb, input logic en, input logic eo);
    int lat;
    send(v, lat);
    chk($sformatf("latency %0d", $signed(v)), 16'(lat), 16'd5);
    chk($sformatf("bcd %0d", $signed(v)), bcd, eb);
    chk($sformatf("neg %0d", $signed(v)), 16'(neg), 16'(en));
    chk($sformatf("ovf %0d", $signed(v)), 16'(ovf), 16'(eo));
  endtask

  initial begin
    logic [15:0] pool [8];
    int nd;
    pool = '{16'd1234, 16'hFFD6, 16'd10000, 16'hFC18, 16'd9999, 16'hFC19, 16'd0, 16'h8000};
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 16'(in_ready), 16'd1);
    chk("rst done", 16'(done), 16'd0);
    chk("rst bcd", bcd, 16'd0);
    chk("rst sel", 16'(sel), 16'b1110);
    chk("rst seg", 16'(seg), 16'hFF);
    rst_n = 1'b1;
    @(posedge clk); #1;
    conv(16'd1234, 16'h1234, 1'b0, 1'b0);
    scan_chk("1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);
    conv(16'hFFD6, 16'h0042, 1'b1, 1'b0);
    scan_chk("-42", 8'hFF, 8'hBF, 8'h99, 8'hA4);
    conv(16'd10000, 16'h0, 1'b0, 1'b1);
    scan_chk("10000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
    conv(16'hFC18, 16'h0, 1'b1, 1'b1);
    conv(16'd9999, 16'h9999, 1'b0, 1'b0);
    conv(16'hFC19, 16'h0999, 1'b1, 1'b0);
    conv(16'd0, 16'h0, 1'b0, 1'b0);
    scan_chk("0", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    conv(16'h8000, 16'h0, 1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_v = 16'd77; nd = 0;
    repeat (6) begin @(posedge clk); #1; nd += int'(done); end
    in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; nd += int'(done); end
    chk("held valid dones", 16'(nd), 16'd1);
    chk("held valid bcd", bcd, 16'h0077);
    in_valid = 1'b1; in_v = 16'hFFFB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst in_ready", 16'(in_ready), 16'd1);
    chk("mid rst done", 16'(done), 16'd0);
    chk("mid rst bcd", bcd, 16'd0);
    chk("mid rst neg", 16'(neg), 16'd0);
    chk("mid rst sel", 16'(sel), 16'b1110);
    chk("mid rst seg", 16'(seg), 16'hFF);
    @(posedge clk); #1 rst_n = 1'b1;
    nd = 0;
    repeat (10) begin @(posedge clk); #1; nd += int'(done); end
    chk("no done after reset", 16'(nd), 16'd0);
    scan_chk("post rst", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    repeat (1500) begin
      @(posedge clk); #1;
      in_valid = ($urandom % 4) == 0;
      in_v = ($urandom % 3 == 0) ? pool[$urandom % 8] : 16'($urandom);
    end
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/disp_split_ctrl.md
DISP_SPLIT_CTRL -- requirements
Module: disp_split_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: sys_clk cycles per displayed digit (1 kHz per digit at 50 MHz); legal range 2..65535.
REQ-002 SHALL have port sys_clk  in  1  sole clock; all flops are rising-edge.
REQ-003 SHALL have port sys_rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  in  1  a new value is offered.
REQ-005 SHALL have port in_v  in  16  signed two's-complement value to display.
REQ-006 SHALL have port in_ready  out  1  block accepts a value; high only in IDLE.
REQ-007 SHALL have port done  out  1  single-cycle pulse when new digits are loaded.
REQ-008 SHALL have port neg  out  1  latched sign of the last accepted value.
REQ-009 SHALL have port ovf  out  1  last accepted value does not fit the display.
REQ-010 SHALL have port bcd  out  16  latched digits {thd,hud,ten,one}, 4 bits each.
REQ-011 SHALL have port seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1.
REQ-012 SHALL have port sel  out  4  digit enables, active-low one-hot; sel[0] = ones digit.

Function
REQ-013 SHALL use FSM states IDLE, LOAD, DIV1, DIV2, DIV3, DONE; the only transitions are IDLE->LOAD on in_valid&in_ready, then LOAD->DIV1->DIV2->DIV3->DONE->IDLE, one cycle each.
REQ-014 SHALL register in_v on the handshake; in_valid while in_ready=0 is ignored (no queueing).
REQ-015 LOAD SHALL compute magnitude = (in_v[15] ? -in_v : in_v) as a 17-bit unsigned value (-32768 -> 32768) into the working register and capture the sign.
REQ-016 LOAD SHALL set the internal overflow flag when magnitude > 9999 with sign 0, or when magnitude > 999 with sign 1.
REQ-017 DIVk SHALL apply the single shared divider to the working register with divisor 10, store R[3:0] as digit k (k=1 one, 2 ten, 3 hud), and write Q back into the working register.
REQ-018 In DONE, the working register[3:0] SHALL become thd, and bcd, neg and ovf SHALL update together.
REQ-019 On overflow, bcd SHALL be forced to 0.
REQ-020 done SHALL pulse for exactly one cycle in DONE.
REQ-021 Fixed latency: done SHALL assert 5 cycles after the handshake edge, including the overflow case.
REQ-022 in_ready SHALL rise in the cycle after DONE.
REQ-023 Display outputs SHALL keep the previous value until DONE.
REQ-024 Scan counter SHALL count 0..SCAN_DIV-1 free-running; on wrap, the 2-bit digit index SHALL advance 0->1->2->3->0 and sel SHALL follow as ~(1<<index).
REQ-025 Segment codes SHALL be: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, minus BF, blank FF (hex).
REQ-026 Leading zeros in thd, hud and ten SHALL be blanked; the ones digit SHALL always be shown.
REQ-027 If neg=1, minus SHALL appear in the position immediately left of the highest non-blank digit.
REQ-028 If ovf=1, all four positions SHALL show minus.
REQ-029 seg and sel SHALL be registered and change on the same edge.

Reset
REQ-030 On sys_rst_n low, asynchronously: state IDLE, in_ready 1, done 0, neg 0, ovf 0, bcd 0, scan counter 0, index 0, sel 4'b1110, seg FF.
REQ-031 After release, the display SHALL show "   0" from the next registered update.
REQ-032 Reset mid-operation SHALL abandon the conversion with no done pulse.

Structure
REQ-033 A shared package/header SHALL hold the state encoding, the segment code constants and the SCAN_DIV default.
REQ-034 SHALL instantiate exactly one existing calc_div (B tied to 16'd10, neg output unused), and SHALL have no other sub-modules.

Verification
REQ-035 in_v=1234 -> done 5 cycles after handshake, bcd=16'h1234, neg=0, ovf=0; sel 0111/1011/1101/1110 carry seg F9/A4/B0/99.
REQ-036 in_v=16'hFFD6 (-42) -> neg=1, bcd=16'h0042; thd FF, hud BF, ten 99, one A4.
REQ-037 in_v=10000 and in_v=-1000 -> ovf=1, bcd=0, all positions BF; in_v=9999 and -999 -> ovf=0.
REQ-038 in_v=0 -> one shows C0, the other three FF; in_v=-32768 -> ovf=1, no X on any output.
REQ-039 in_valid held high through busy -> exactly one conversion, second accepted only after in_ready rises; rst_n low during DIV2 -> immediate reset values, no done.
REQ-040 SCAN_DIV=4 -> sel steps 1110->1101->1011->0111->1110 every 4 cycles, unaffected by concurrent conversions.
